// File: rtl/lorenz_pkg.sv
// Shared types for the Lorenz integrator bank and its step controller.
package lorenz_pkg;

    localparam int WIDTH = 27;
    localparam int FRAC  = 20;

    typedef logic signed [WIDTH-1:0] fixed_t;

    typedef struct packed {
        fixed_t x;
        fixed_t y;
        fixed_t z;
    } xyz_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/lorenz_step_ctrl_step_timer.sv
// Step pacing counters: div_cnt counts cycles inside one step period,
// dec_cnt counts steps inside one sample period.
module step_timer #(
    parameter int DIV_W = 16,
    parameter int DEC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             adv_i,
    input  logic             step_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic [DEC_W-1:0] cfg_dec_i,
    output logic             div_term_o,
    output logic             smp_step_o
);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic [DEC_W-1:0] dec_cnt_q;
    logic [DEC_W-1:0] dec_cnt_d;

    assign div_term_o = (div_cnt_q == cfg_div_i);
    assign smp_step_o = (dec_cnt_q == cfg_dec_i);

    // Next-state for the pacing counters; a stalled terminal count simply holds.
    always_comb begin
        div_cnt_d = div_cnt_q;
        dec_cnt_d = dec_cnt_q;
        if (clear_i) begin
            div_cnt_d = {DIV_W{1'b0}};
            dec_cnt_d = {DEC_W{1'b0}};
        end else if (step_i) begin
            div_cnt_d = {DIV_W{1'b0}};
            if (smp_step_o) begin
                dec_cnt_d = {DEC_W{1'b0}};
            end else begin
                dec_cnt_d = dec_cnt_q + DEC_W'(1);
            end
        end else if (adv_i && !div_term_o) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end else begin
            div_cnt_d = div_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= {DIV_W{1'b0}};
            dec_cnt_q <= {DEC_W{1'b0}};
        end else begin
            div_cnt_q <= div_cnt_d;
            dec_cnt_q <= dec_cnt_d;
        end
    end

endmodule

// File: rtl/lorenz_step_ctrl.sv
// Sequencing controller for the Lorenz integrator bank: config handshake,
// integrator load, paced Euler step enables and decimated state capture.
module lorenz_step_ctrl #(
    parameter int WIDTH = 27,
    parameter int DIV_W = 16,
    parameter int DEC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_init_x,
    input  logic [WIDTH-1:0] cfg_init_y,
    input  logic [WIDTH-1:0] cfg_init_z,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DEC_W-1:0] cfg_dec,
    input  logic             run,
    input  logic [WIDTH-1:0] state_x,
    input  logic [WIDTH-1:0] state_y,
    input  logic [WIDTH-1:0] state_z,
    output logic             int_load,
    output logic [WIDTH-1:0] int_init_x,
    output logic [WIDTH-1:0] int_init_y,
    output logic [WIDTH-1:0] int_init_z,
    output logic             int_step,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic [WIDTH-1:0] smp_x,
    output logic [WIDTH-1:0] smp_y,
    output logic [WIDTH-1:0] smp_z,
    output logic [31:0]      step_count,
    output logic             busy
);

    lorenz_pkg::ctrl_state_e state_q, state_d;
    logic             loaded_q, loaded_d;
    logic [WIDTH-1:0] init_x_q, init_x_d;
    logic [WIDTH-1:0] init_y_q, init_y_d;
    logic [WIDTH-1:0] init_z_q, init_z_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DEC_W-1:0] dec_q, dec_d;
    logic             cap_pend_q, cap_pend_d;
    logic             smp_valid_q, smp_valid_d;
    logic [WIDTH-1:0] smp_x_q, smp_x_d;
    logic [WIDTH-1:0] smp_y_q, smp_y_d;
    logic [WIDTH-1:0] smp_z_q, smp_z_d;
    logic [31:0]      step_count_q, step_count_d;

    logic in_idle_s, in_load_s, in_run_s;
    logic adv_s, div_term_s, smp_step_s, stall_s, step_s, cfg_hs_s;

    assign in_idle_s = (state_q == lorenz_pkg::ST_IDLE);
    assign in_load_s = (state_q == lorenz_pkg::ST_LOAD);
    assign in_run_s  = (state_q == lorenz_pkg::ST_RUN);
    assign adv_s     = in_run_s & run;
    assign cfg_hs_s  = in_idle_s & cfg_valid;

    // A sample step may not fire while the previous sample is still being
    // captured or is still waiting on the downstream consumer.
    assign stall_s = smp_step_s & (cap_pend_q | (smp_valid_q & ~smp_ready));
    assign step_s  = adv_s & div_term_s & ~stall_s;

    step_timer #(
        .DIV_W (DIV_W),
        .DEC_W (DEC_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (in_load_s),
        .adv_i      (adv_s),
        .step_i     (step_s),
        .cfg_div_i  (div_q),
        .cfg_dec_i  (dec_q),
        .div_term_o (div_term_s),
        .smp_step_o (smp_step_s)
    );

    // FSM, config latch, step counter and capture next-state.
    always_comb begin
        state_d      = state_q;
        loaded_d     = loaded_q;
        init_x_d     = init_x_q;
        init_y_d     = init_y_q;
        init_z_d     = init_z_q;
        div_d        = div_q;
        dec_d        = dec_q;
        cap_pend_d   = cap_pend_q;
        smp_valid_d  = smp_valid_q;
        smp_x_d      = smp_x_q;
        smp_y_d      = smp_y_q;
        smp_z_d      = smp_z_q;
        step_count_d = step_count_q;

        case (state_q)
            lorenz_pkg::ST_IDLE: begin
                if (cfg_hs_s) begin
                    init_x_d = cfg_init_x;
                    init_y_d = cfg_init_y;
                    init_z_d = cfg_init_z;
                    div_d    = cfg_div;
                    dec_d    = cfg_dec;
                    state_d  = lorenz_pkg::ST_LOAD;
                end else if (run && loaded_q) begin
                    state_d = lorenz_pkg::ST_RUN;
                end else begin
                    state_d = lorenz_pkg::ST_IDLE;
                end
            end
            lorenz_pkg::ST_LOAD: begin
                loaded_d = 1'b1;
                if (run) begin
                    state_d = lorenz_pkg::ST_RUN;
                end else begin
                    state_d = lorenz_pkg::ST_IDLE;
                end
            end
            lorenz_pkg::ST_RUN: begin
                if (!run) begin
                    state_d = lorenz_pkg::ST_IDLE;
                end else begin
                    state_d = lorenz_pkg::ST_RUN;
                end
            end
            default: begin
                state_d = lorenz_pkg::ST_IDLE;
            end
        endcase

        if (in_load_s) begin
            step_count_d = 32'd0;
            cap_pend_d   = 1'b0;
            smp_valid_d  = 1'b0;
        end else begin
            if (step_s) begin
                step_count_d = step_count_q + 32'd1;
            end else begin
                step_count_d = step_count_q;
            end
            // Capture takes priority over the consumer's acknowledge.
            if (cap_pend_q) begin
                smp_x_d     = state_x;
                smp_y_d     = state_y;
                smp_z_d     = state_z;
                smp_valid_d = 1'b1;
            end else if (smp_valid_q && smp_ready) begin
                smp_valid_d = 1'b0;
            end else begin
                smp_valid_d = smp_valid_q;
            end
            cap_pend_d = step_s & smp_step_s;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= lorenz_pkg::ST_IDLE;
            loaded_q     <= 1'b0;
            init_x_q     <= {WIDTH{1'b0}};
            init_y_q     <= {WIDTH{1'b0}};
            init_z_q     <= {WIDTH{1'b0}};
            div_q        <= {DIV_W{1'b0}};
            dec_q        <= {DEC_W{1'b0}};
            cap_pend_q   <= 1'b0;
            smp_valid_q  <= 1'b0;
            smp_x_q      <= {WIDTH{1'b0}};
            smp_y_q      <= {WIDTH{1'b0}};
            smp_z_q      <= {WIDTH{1'b0}};
            step_count_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            loaded_q     <= loaded_d;
            init_x_q     <= init_x_d;
            init_y_q     <= init_y_d;
            init_z_q     <= init_z_d;
            div_q        <= div_d;
            dec_q        <= dec_d;
            cap_pend_q   <= cap_pend_d;
            smp_valid_q  <= smp_valid_d;
            smp_x_q      <= smp_x_d;
            smp_y_q      <= smp_y_d;
            smp_z_q      <= smp_z_d;
            step_count_q <= step_count_d;
        end
    end

    assign cfg_ready  = in_idle_s;
    assign int_load   = in_load_s;
    assign busy       = in_run_s;
    assign int_step   = step_s;
    assign int_init_x = init_x_q;
    assign int_init_y = init_y_q;
    assign int_init_z = init_z_q;
    assign smp_valid  = smp_valid_q;
    assign smp_x      = smp_x_q;
    assign smp_y      = smp_y_q;
    assign smp_z      = smp_z_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_lorenz_step_ctrl.sv
// Self-checking bench for lorenz_step_ctrl with a cycle-level reference
// model expressed in terms of waiting cycles, step counts and sample slots.
module tb_lorenz_step_ctrl;

    localparam int WIDTH = 27;
    localparam int DIV_W = 16;
    localparam int DEC_W = 8;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_init_x, cfg_init_y, cfg_init_z;
    logic [DIV_W-1:0] cfg_div;
    logic [DEC_W-1:0] cfg_dec;
    logic             run;
    logic [WIDTH-1:0] state_x, state_y, state_z;
    logic             int_load;
    logic [WIDTH-1:0] int_init_x, int_init_y, int_init_z;
    logic             int_step;
    logic             smp_valid;
    logic             smp_ready;
    logic [WIDTH-1:0] smp_x, smp_y, smp_z;
    logic [31:0]      step_count;
    logic             busy;

    always #5 clk = ~clk;

    lorenz_step_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W), .DEC_W(DEC_W)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_init_x(cfg_init_x), .cfg_init_y(cfg_init_y), .cfg_init_z(cfg_init_z),
        .cfg_div(cfg_div), .cfg_dec(cfg_dec), .run(run),
        .state_x(state_x), .state_y(state_y), .state_z(state_z),
        .int_load(int_load),
        .int_init_x(int_init_x), .int_init_y(int_init_y), .int_init_z(int_init_z),
        .int_step(int_step), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_x(smp_x), .smp_y(smp_y), .smp_z(smp_z),
        .step_count(step_count), .busy(busy)
    );

    // Fake integrator outputs, owned by the bench.
    logic [WIDTH-1:0] st [3];
    assign state_x = st[0];
    assign state_y = st[1];
    assign state_z = st[2];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state.
    int               m_mode;
    bit               m_loaded;
    int unsigned      m_div, m_dec;
    logic [WIDTH-1:0] m_init [3];
    int unsigned      m_wait;     // eligible RUN cycles waited since last step
    logic [31:0]      m_steps;    // steps since last load (wrapping)
    int unsigned      m_since;    // steps since last load, for decimation
    bit               m_cap;      // capture due this cycle
    bit               m_sv;       // sample held for downstream
    logic [WIDTH-1:0] m_smp [3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_loaded = 1'b0; m_div = 0; m_dec = 0;
        m_wait = 0; m_steps = 32'd0; m_since = 0; m_cap = 1'b0; m_sv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_init[i] = '0;
            m_smp[i]  = '0;
        end
    endtask

    // One clock cycle: entered at posedge+1 with inputs already driven.
    task automatic cycle();
        bit elig, sample, blocked, step, load;
        #3;
        elig    = (m_mode == M_RUN) && run;
        sample  = ((m_since % (m_dec + 1)) == m_dec);
        blocked = sample && (m_cap || (m_sv && !smp_ready));
        step    = elig && (m_wait == m_div) && !blocked;
        load    = (m_mode == M_LOAD);

        check("cfg_ready",  64'(cfg_ready),  64'(m_mode == M_IDLE));
        check("busy",       64'(busy),       64'(m_mode == M_RUN));
        check("int_load",   64'(int_load),   64'(load));
        check("int_step",   64'(int_step),   64'(step));
        check("smp_valid",  64'(smp_valid),  64'(m_sv));
        check("step_count", 64'(step_count), 64'(m_steps));
        check("int_init_x", 64'(int_init_x), 64'(m_init[0]));
        check("int_init_z", 64'(int_init_z), 64'(m_init[2]));
        check("smp_x",      64'(smp_x),      64'(m_smp[0]));
        check("smp_y",      64'(smp_y),      64'(m_smp[1]));
        check("smp_z",      64'(smp_z),      64'(m_smp[2]));

        if (load) begin
            m_wait = 0; m_steps = 32'd0; m_since = 0;
            m_cap = 1'b0; m_sv = 1'b0; m_loaded = 1'b1;
            m_mode = run ? M_RUN : M_IDLE;
        end else begin
            if (step) begin
                m_wait = 0; m_steps = m_steps + 32'd1; m_since++;
            end else if (elig && m_wait < m_div) begin
                m_wait++;
            end
            if (m_cap) begin
                m_smp = st;
                m_sv  = 1'b1;
            end else if (m_sv && smp_ready) begin
                m_sv = 1'b0;
            end
            m_cap = step && sample;
            if (m_mode == M_IDLE) begin
                if (cfg_valid) begin
                    m_init[0] = cfg_init_x; m_init[1] = cfg_init_y; m_init[2] = cfg_init_z;
                    m_div = cfg_div; m_dec = cfg_dec;
                    m_mode = M_LOAD;
                end else if (run && m_loaded) begin
                    m_mode = M_RUN;
                end
            end else if (m_mode == M_RUN && !run) begin
                m_mode = M_IDLE;
            end
        end

        @(posedge clk);
        #1;
        if (load) begin
            st = m_init;
        end else if (step) begin
            for (int i = 0; i < 3; i++) st[i] = WIDTH'($urandom);
        end
    endtask

    // Return to IDLE if needed, then offer one configuration for one cycle.
    task automatic do_cfg(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic [WIDTH-1:0] z, input int unsigned dv, input int unsigned dc);
        int k;
        run = 1'b0;
        k = 0;
        while (m_mode != M_IDLE && k < 10) begin
            cycle();
            k++;
        end
        check("reach_idle", 64'(m_mode == M_IDLE), 64'(1));
        cfg_init_x = x; cfg_init_y = y; cfg_init_z = z;
        cfg_div = DIV_W'(dv); cfg_dec = DEC_W'(dc);
        cfg_valid = 1'b1;
        cycle();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int k;
        reset = 1'b1; cfg_valid = 1'b0; run = 1'b0; smp_ready = 1'b1;
        cfg_init_x = '0; cfg_init_y = '0; cfg_init_z = '0; cfg_div = '0; cfg_dec = '0;
        for (int i = 0; i < 3; i++) st[i] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_init_x", 64'(int_init_x), 64'(0));
        check("rst_cfg_ready", 64'(cfg_ready), 64'(1));
        cycle();

        // Initial conditions -1.0 / 0.1 / 25.0, step every 4th cycle.
        run = 1'b1;
        cfg_init_x = 27'h7F00000; cfg_init_y = 27'h001999A; cfg_init_z = 27'h1900000;
        cfg_div = 16'd3; cfg_dec = 8'd0; cfg_valid = 1'b1;
        cycle();
        cfg_valid = 1'b0;
        check("load_pulse", 64'(int_load), 64'(1));
        check("init_x_const", 64'(int_init_x), 64'(27'h7F00000));
        repeat (5) cycle();
        check("cnt_1", 64'(step_count), 64'(1));
        repeat (4) cycle();
        check("cnt_2", 64'(step_count), 64'(2));
        repeat (4) cycle();
        check("cnt_3", 64'(step_count), 64'(3));
        repeat (10) cycle();

        // Decimate by 5, single-cycle steps.
        do_cfg(27'h0100000, 27'h0200000, 27'h0300000, 0, 4);
        run = 1'b1; smp_ready = 1'b1;
        repeat (40) cycle();

        // Backpressure: only one step gets through.
        do_cfg(27'h0010000, 27'h0020000, 27'h0030000, 0, 0);
        run = 1'b1; smp_ready = 1'b0;
        repeat (20) cycle();
        check("stall_cnt", 64'(step_count), 64'(1));
        check("stall_step", 64'(int_step), 64'(0));
        smp_ready = 1'b1;
        repeat (10) cycle();

        // run dropped mid-divide with div_cnt at 5.
        do_cfg(27'h0000100, 27'h0000200, 27'h0000300, 9, 0);
        run = 1'b1;
        k = 0;
        while (!(m_mode == M_RUN && m_wait == 5) && k < 40) begin
            cycle();
            k++;
        end
        check("reach_mid_divide", 64'(m_wait), 64'(5));
        run = 1'b0;
        repeat (7) cycle();
        run = 1'b1;
        repeat (15) cycle();

        // Config offered during RUN is ignored.
        cfg_init_x = 27'h5555555; cfg_div = 16'd1; cfg_valid = 1'b1;
        repeat (3) cycle();
        cfg_valid = 1'b0;
        check("init_held", 64'(int_init_x), 64'(27'h0000100));
        do_cfg(27'h0ABCDEF, 27'h0123456, 27'h7654321, 2, 1);
        cycle();
        check("load_clears_cnt", 64'(step_count), 64'(0));

        // Randomized operation with occasional reconfiguration.
        for (int i = 0; i < 400; i++) begin
            run       = ($urandom_range(0, 9) != 0);
            smp_ready = ($urandom_range(0, 3) != 0);
            cfg_valid = ($urandom_range(0, 39) == 0);
            if (cfg_valid) begin
                cfg_init_x = WIDTH'($urandom); cfg_init_y = WIDTH'($urandom);
                cfg_init_z = WIDTH'($urandom);
                cfg_div = DIV_W'($urandom_range(0, 4));
                cfg_dec = DEC_W'($urandom_range(0, 3));
            end
            cycle();
        end
        cfg_valid = 1'b0;

        // Asynchronous reset in RUN while a sample is held.
        do_cfg(27'h0000011, 27'h0000022, 27'h0000033, 0, 0);
        run = 1'b1; smp_ready = 1'b0;
        k = 0;
        while (!m_sv && k < 20) begin
            cycle();
            k++;
        end
        check("reach_smp_valid", 64'(m_sv), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_smp_valid", 64'(smp_valid), 64'(0));
        check("arst_step_count", 64'(step_count), 64'(0));
        check("arst_int_step", 64'(int_step), 64'(0));
        check("arst_cfg_ready", 64'(cfg_ready), 64'(1));
        check("arst_init_x", 64'(int_init_x), 64'(0));
        check("arst_smp_x", 64'(smp_x), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run = 1'b1; smp_ready = 1'b1;
        repeat (8) cycle();
        check("no_restart", 64'(busy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lorenz_step_ctrl.md
# lorenz_step_ctrl

Sequencing controller for the Lorenz fixed-point integrator bank (X/Y/Z state registers in 7.20 two's complement). It accepts initial-condition and rate configuration over a valid/ready handshake and forces the integrators to load. It then issues single-cycle Euler step enables at a programmable cycle rate. Every Nth step it captures the state into an output sample register for the downstream plotter/VGA writer, stalling stepping under backpressure.

## Interface
Parameters:
- WIDTH, 27, state word width (7.20 signed)
- DIV_W, 16, width of cycles-per-step divider
- DEC_W, 8, width of steps-per-sample decimator

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted when both high
- cfg_init_x/y/z  in  WIDTH each  initial state
- cfg_div  in  DIV_W  cycles per step minus 1
- cfg_dec  in  DEC_W  steps per sample minus 1
- run  in  1  level; 1 = stepping permitted
- state_x/y/z  in  WIDTH each  current integrator outputs
- int_load  out  1  integrators load int_init_* this edge
- int_init_x/y/z  out  WIDTH each  latched initial state
- int_step  out  1  integrators apply one Euler update this edge
- smp_valid  out  1  sample available
- smp_ready  in  1  downstream accepts sample
- smp_x/y/z  out  WIDTH each  captured state
- step_count  out  32  steps issued since last load
- busy  out  1  high in RUN

## Operation
- States: IDLE, LOAD, RUN.
- IDLE:
  - cfg_ready=1.
  - cfg_valid=1 latches all cfg_* fields, goes to LOAD.
  - Else, if run=1 and loaded=1, goes to RUN.
- LOAD (1 cycle):
  - int_load=1.
  - Clears div_cnt, dec_cnt, step_count, cap_pend and smp_valid. Sets loaded.
  - Goes to RUN if run=1, else IDLE.
- RUN:
  - cfg_ready=0; cfg_valid is ignored.
  - run=0 goes to IDLE. Counters hold and no step is issued that cycle.
- Step rule: int_step = RUN & run & (div_cnt==cfg_div) & !stall.
  - On step: div_cnt←0, step_count+1 (wraps at 2^32), dec_cnt+1.
  - If dec_cnt==cfg_dec, the step is a sample step: dec_cnt←0, cap_pend←1.
  - Otherwise, div_cnt increments while div_cnt<cfg_div.
  - When div_cnt is terminal and the step is stalled, div_cnt holds.
- stall = sample step pending & (cap_pend | (smp_valid & !smp_ready)). Non-sample steps never stall.
- Capture: cap_pend=1 in a cycle → smp_x/y/z←state_x/y/z, smp_valid←1, cap_pend←0. This captures post-step state.
- smp_valid clears on smp_valid & smp_ready unless a capture occurs the same edge; capture wins.
- int_init_* = latched config registers, stable except at a cfg handshake.
- Arithmetic: counters are unsigned and never compared signed. The controller does no state arithmetic.

## Timing
- Reset values:
  - State IDLE; loaded=0; all config registers 0.
  - cfg_ready=1.
  - int_load=0, int_step=0, int_init_*=0.
  - smp_valid=0, smp_*=0, step_count=0, busy=0.
- cfg handshake at cycle t → int_load=1 at t+1 → first RUN cycle t+2 (when run=1).
- First int_step comes in the first RUN cycle + cfg_div.
- Sample step at t → smp_valid visible t+2, with data = state after step t.
- With cfg_div=0, cfg_dec=0 and smp_ready=1: one step per cycle except stalls from cap_pend. Sustained rate is one sample every 2 cycles.
- Reset mid-RUN: immediate return to reset values. The integrators are not reloaded until a new cfg handshake.
- run toggling: no step is lost or duplicated. Counters resume from held values.

## Structure
- lorenz_pkg holds:
  - WIDTH=27 and FRAC=20
  - typedef fixed_t (signed [WIDTH-1:0])
  - typedef xyz_t (struct of three fixed_t)
  - ctrl state enum {IDLE, LOAD, RUN}
- Sub-module step_timer holds div_cnt and dec_cnt plus the terminal/sample-step flags. The top keeps the FSM, capture register and handshakes.

## Test plan
- Reset then cfg (init -1.0/0.1/25.0, div=3, dec=0), run=1 → int_load pulse at t+1, int_init_x=27'h7F00000, int_step every 4th cycle, step_count=1,2,3.
- div=0, dec=4, smp_ready=1 → smp_valid every 5 steps; smp_* equal state_* one cycle after the 5th step.
- smp_ready=0 for 20 cycles, dec=0, div=0 → exactly one step issued and then int_step held low. On smp_ready=1, stepping resumes with no extra step_count.
- run dropped mid-divide (div=9, div_cnt=5) for 7 cycles → no int_step. The step fires 4 RUN cycles after run returns.
- cfg_valid asserted in RUN → cfg_ready=0, config unchanged; run=0 → IDLE, handshake accepted, LOAD clears step_count to 0.
- Async reset asserted mid-cycle during RUN with smp_valid=1 → all outputs 0 immediately, state IDLE, run=1 alone does not restart (loaded=0).
